split_order_merge: RTL and testbench
====================================

// Module: split_order_merge
// PURPOSE
//  Re-merges the two branches of a snoop splitter in arrival order. The splitter pushes one branch
//  choice per packet (on that packet's done). This block queues those choices and serves one VM at a
//  time, oldest packet first. It waits for that VM's verdict, then either drops the packet or lends
//  the single forwarder's read port to that VM's packet memory. Sits between split stage VMs and forwarder.
// PARAMETERS
//  DATA_WIDTH      64  packet memory read data width
//  ADDR_WIDTH      10  packet memory read address width
//  ORDER_DEPTH_LOG 4   log2 of order-queue depth (queue holds 2**ORDER_DEPTH_LOG choices)
// PORTS
//  clk           in   1           single clock; all logic on posedge
//  rst           in   1           asynchronous, active-high reset
//  sel_in        in   1           branch choice for the packet just finished (0 left, 1 right)
//  sel_wr        in   1           push sel_in into order queue (one pulse per packet)
//  sel_full      out  1           order queue full
//  overflow      out  1           sticky: a push was dropped because queue was full
//  vld_left      in   1           left VM holds a verdict (level, held until ack_left)
//  acc_left      in   1           left verdict: 1 accept (forward), 0 reject; valid with vld_left
//  ack_left      out  1           one-cycle pulse: left verdict consumed
//  rd_en_left    out  1           left packet memory read enable
//  rd_addr_left  out  ADDR_WIDTH  left packet memory read address
//  rd_data_left  in   DATA_WIDTH  left packet memory read data (1-cycle memory latency)
//  done_left     out  1           left packet fully forwarded, memory may be freed
//  vld_right/acc_right/ack_right/rd_en_right/rd_addr_right/rd_data_right/done_right: same, right VM
//  fwd_pkt_ready out  1           a packet is available to the forwarder
//  fwd_src       out  1           branch currently lent to forwarder
//  fwd_rd_en     in   1           forwarder read enable
//  fwd_rd_addr   in   ADDR_WIDTH  forwarder read address
//  fwd_rd_data   out  DATA_WIDTH  read data from the selected branch
//  fwd_done      in   1           forwarder finished current packet
// BEHAVIOUR
//  Reset (async, any state): queue emptied, FSM->IDLE, overflow=0.
//   All outputs 0: sel_full, ack_*, rd_en_*, rd_addr_*, done_*, fwd_pkt_ready, fwd_src, fwd_rd_data.
//  Order queue: FIFO, registered pointers with one extra wrap bit; full when ptrs differ only in MSB.
//   Push on sel_wr&&!full. Push while full is dropped and sets overflow until reset.
//   Simultaneous push+pop is legal when full: both happen, count unchanged.
//  FSM (state registered):
//   IDLE: queue empty. Go to WAIT the cycle after queue becomes non-empty.
//   WAIT: head=queue head (h). Verdict valid on branch h:
//    - reject: ack_h=1 this cycle, pop; next state WAIT if another entry remains, else IDLE.
//    - accept: ack_h=1 this cycle, fwd_src<=h; next state FWD.
//    Verdicts on the non-head branch are ignored (left pending, no ack).
//  FWD: fwd_pkt_ready=1. fwd_rd_en/fwd_rd_addr route combinationally to rd_*_h; the other branch's
//   rd_en stays 0. fwd_rd_data=rd_data_h.
//   fwd_done: done_h=1 the same cycle, pop, next state WAIT/IDLE as above.
//   At most one packet in flight; back-to-back packets cost 1 WAIT cycle minimum.
//  fwd_rd_addr passes to both rd_addr_* outputs unchanged (widths equal, no arithmetic).
//  Outside FWD, fwd_rd_data=0 and fwd_rd_en is ignored.
//  fwd_done outside FWD is ignored.
//  Reset mid-FWD: rd_en_*/done_* drop to 0 immediately. The in-flight packet is abandoned.
// STRUCTURE
//  Shared package/header: FSM state encoding (IDLE=2'd0, WAIT=2'd1, FWD=2'd2), BRANCH_LEFT=0/BRANCH_RIGHT=1.
//  Sub-module: order_fifo (1-bit wide, depth 2**ORDER_DEPTH_LOG, async reset, full/empty, push/pop).
//   This module holds the FSM and the read-port mux only.
// TESTING
//  1. Push L,R,L; VMs all accept; forwarder reads 4 words each.
//     -> done_left, done_right, done_left in that order; fwd_rd_data matches each VM memory.
//  2. Push L,R; right verdict (accept) arrives 10 cycles before left.
//     -> no ack_right until left forwarded; then right forwarded.
//  3. Push R; right rejects.
//     -> ack_right 1 cycle, no rd_en_right, done_right stays 0, FSM back to IDLE, queue empty.
//  4. Depth 16: 16 pushes -> sel_full=1; 17th push -> overflow=1.
//     Push+pop same cycle while full -> count stays 16.
//  5. Assert rst while in FWD after 2 of 4 reads.
//     -> all outputs 0 same cycle; after release, queue empty, new packet forwards normally.
//  6. fwd_done while in WAIT/IDLE -> no done_*, no pop.
//     fwd_rd_en while in WAIT -> no rd_en_* asserted.

Source files
------------

// File: rtl/split_order_merge_pkg.sv
// Shared types for the snoop-split re-merge block: FSM encoding and branch ids.
package split_order_merge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FWD  = 2'd2
   } state_t;

   localparam logic BRANCH_LEFT  = 1'b0;
   localparam logic BRANCH_RIGHT = 1'b1;
   localparam int   NUM_BR       = 2;

endpackage

// File: rtl/split_order_merge_if.sv
// Bundle of the splitter order port, both VM ports and the forwarder port.
interface split_order_merge_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10
);
   logic                  sel_in, sel_wr, sel_full, overflow;
   logic                  vld_left, acc_left, ack_left, rd_en_left, done_left;
   logic [ADDR_WIDTH-1:0] rd_addr_left;
   logic [DATA_WIDTH-1:0] rd_data_left;
   logic                  vld_right, acc_right, ack_right, rd_en_right, done_right;
   logic [ADDR_WIDTH-1:0] rd_addr_right;
   logic [DATA_WIDTH-1:0] rd_data_right;
   logic                  fwd_pkt_ready, fwd_src, fwd_rd_en, fwd_done;
   logic [ADDR_WIDTH-1:0] fwd_rd_addr;
   logic [DATA_WIDTH-1:0] fwd_rd_data;

   modport slave (
      input  sel_in, sel_wr,
      output sel_full, overflow,
      input  vld_left, acc_left, rd_data_left,
      output ack_left, rd_en_left, rd_addr_left, done_left,
      input  vld_right, acc_right, rd_data_right,
      output ack_right, rd_en_right, rd_addr_right, done_right,
      input  fwd_rd_en, fwd_rd_addr, fwd_done,
      output fwd_pkt_ready, fwd_src, fwd_rd_data
   );

   modport master (
      output sel_in, sel_wr,
      input  sel_full, overflow,
      output vld_left, acc_left, rd_data_left,
      input  ack_left, rd_en_left, rd_addr_left, done_left,
      output vld_right, acc_right, rd_data_right,
      input  ack_right, rd_en_right, rd_addr_right, done_right,
      output fwd_rd_en, fwd_rd_addr, fwd_done,
      input  fwd_pkt_ready, fwd_src, fwd_rd_data
   );
endinterface

// File: rtl/split_order_merge_order_fifo.sv
// 1-bit FIFO of branch choices; wrap-bit pointers, sticky overflow on a dropped push.
module order_fifo #(
   parameter int DEPTH_LOG = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               din,
   output logic               dout,
   output logic               full,
   output logic               empty,
   output logic [DEPTH_LOG:0] count,
   output logic               overflow
);
   localparam int DEPTH = 2 ** DEPTH_LOG;

   logic [DEPTH_LOG:0] wr_ptr, rd_ptr;
   logic [DEPTH-1:0]   mem;
   logic               do_push, do_pop;

   assign full    = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                    (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[DEPTH_LOG-1:0]];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)         wr_ptr   <= wr_ptr + 1'b1;
         if (do_pop)          rd_ptr   <= rd_ptr + 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= din;
   end
endmodule

// File: rtl/split_order_merge.sv
// Serves the two split-stage VMs in packet arrival order and lends the
// forwarder's single read port to the VM whose packet is at the queue head.
module split_order_merge
   import split_order_merge_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 10,
   parameter int ORDER_DEPTH_LOG = 4
) (
   input logic                clk,
   input logic                rst,
   split_order_merge_if.slave bus
);
   localparam int CNT_W = ORDER_DEPTH_LOG + 1;

   state_t state, nxt;
   logic   fwd_src_q, src_load, pop, head, empty, full;
   logic   more;
   logic [CNT_W-1:0] count;

   logic [NUM_BR-1:0]                 vld, acc, ack, done, rd_en;
   logic [NUM_BR-1:0][DATA_WIDTH-1:0] rd_data;

   assign vld     = {bus.vld_right, bus.vld_left};
   assign acc     = {bus.acc_right, bus.acc_left};
   assign rd_data = {bus.rd_data_right, bus.rd_data_left};

   order_fifo #(.DEPTH_LOG(ORDER_DEPTH_LOG)) u_order (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.sel_wr),
      .pop      (pop),
      .din      (bus.sel_in),
      .dout     (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (bus.overflow)
   );

   // After popping the head, another entry remains if more than one was queued
   // or a push is landing this cycle (only matters when the queue is not full).
   assign more = (count > CNT_W'(1)) || bus.sel_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         fwd_src_q <= BRANCH_LEFT;
      end else begin
         state <= nxt;
         if (src_load) fwd_src_q <= head;
      end
   end

   always_comb begin
      nxt      = state;
      ack      = '0;
      done     = '0;
      pop      = 1'b0;
      src_load = 1'b0;
      case (state)
         ST_IDLE: if (!empty) nxt = ST_WAIT;
         ST_WAIT: begin
            if (!empty && vld[head]) begin
               ack[head] = 1'b1;
               if (acc[head]) begin
                  src_load = 1'b1;
                  nxt      = ST_FWD;
               end else begin
                  pop = 1'b1;
                  nxt = more ? ST_WAIT : ST_IDLE;
               end
            end
         end
         ST_FWD: begin
            if (bus.fwd_done) begin
               done[fwd_src_q] = 1'b1;
               pop             = 1'b1;
               nxt             = more ? ST_WAIT : ST_IDLE;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   for (genvar g = 0; g < NUM_BR; g++) begin : g_br
      assign rd_en[g] = (state == ST_FWD) && (fwd_src_q == 1'(g)) && bus.fwd_rd_en;
   end

   assign bus.sel_full      = full;
   assign bus.ack_left      = ack[BRANCH_LEFT];
   assign bus.ack_right     = ack[BRANCH_RIGHT];
   assign bus.done_left     = done[BRANCH_LEFT];
   assign bus.done_right    = done[BRANCH_RIGHT];
   assign bus.rd_en_left    = rd_en[BRANCH_LEFT];
   assign bus.rd_en_right   = rd_en[BRANCH_RIGHT];
   // Address is shared by both memories; only held low while reset is asserted.
   assign bus.rd_addr_left  = rst ? '0 : bus.fwd_rd_addr;
   assign bus.rd_addr_right = rst ? '0 : bus.fwd_rd_addr;
   assign bus.fwd_pkt_ready = (state == ST_FWD);
   assign bus.fwd_src       = fwd_src_q;
   assign bus.fwd_rd_data   = (state == ST_FWD) ? rd_data[fwd_src_q] : '0;
endmodule

// File: tb/tb_split_order_merge.sv
// Directed + randomized bench for split_order_merge against an arrival-order packet queue model.
module tb_split_order_merge;
   localparam int DW = 64;
   localparam int AW = 10;
   localparam int DL = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   split_order_merge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   split_order_merge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ORDER_DEPTH_LOG(DL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct { bit b; bit acc; } pkt_t;
   pkt_t          pend[$];
   bit            raised[2];
   logic [DW-1:0] mem[2][1024];
   int            checks = 0;
   int            errors = 0;

   // VM packet memories: one-cycle read latency
   always @(posedge clk) begin
      if (bus.rd_en_left)  bus.rd_data_left  <= mem[0][bus.rd_addr_left];
      if (bus.rd_en_right) bus.rd_data_right <= mem[1][bus.rd_addr_right];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic ack_o(bit b);   return b ? bus.ack_right   : bus.ack_left;   endfunction
   function automatic logic rden_o(bit b);  return b ? bus.rd_en_right : bus.rd_en_left; endfunction
   function automatic logic done_o(bit b);  return b ? bus.done_right  : bus.done_left;  endfunction
   function automatic logic [AW-1:0] addr_o(bit b);
      return b ? bus.rd_addr_right : bus.rd_addr_left;
   endfunction

   task automatic raise(bit b, bit a);
      if (b) begin bus.vld_right = 1'b1; bus.acc_right = a; end
      else   begin bus.vld_left  = 1'b1; bus.acc_left  = a; end
      raised[b] = 1'b1;
   endtask

   task automatic drop(bit b);
      if (b) bus.vld_right = 1'b0; else bus.vld_left = 1'b0;
      raised[b] = 1'b0;
   endtask

   // All tasks start and end right at a falling edge.
   task automatic push(bit b, bit a, bit model);
      bus.sel_wr = 1'b1;
      bus.sel_in = b;
      @(negedge clk);
      bus.sel_wr = 1'b0;
      if (model) pend.push_back(pkt_t'{b: b, acc: a});
   endtask

   task automatic wait_ack(bit b, string tag);
      bit seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         #1;
         chk({tag, "_ack_other"}, ack_o(!b), 1'b0);
         seen = ack_o(b);
         @(negedge clk);
      end
      chk({tag, "_ack"}, seen, 1'b1);
      drop(b);
   endtask

   task automatic fwd_packet(bit b, int n);
      int base = $urandom_range(0, 1000);
      for (int i = 0; i <= n; i++) begin
         bus.fwd_rd_en   = (i < n);
         bus.fwd_rd_addr = AW'(base + i);
         #1;
         if (i == 0) begin
            chk("fwd_ready", bus.fwd_pkt_ready, 1'b1);
            chk("fwd_src", bus.fwd_src, b);
         end
         if (i < n) begin
            chk("rd_en_sel", rden_o(b), 1'b1);
            chk("rd_en_other", rden_o(!b), 1'b0);
            chk("rd_addr", addr_o(b), base + i);
         end
         if (i > 0) chk("fwd_rd_data", bus.fwd_rd_data, mem[b][base + i - 1]);
         @(negedge clk);
      end
      bus.fwd_rd_en = 1'b0;
      bus.fwd_done  = 1'b1;
      #1;
      chk("done_sel", done_o(b), 1'b1);
      chk("done_other", done_o(!b), 1'b0);
      @(negedge clk);
      bus.fwd_done = 1'b0;
   endtask

   // Oldest pending packet is served; optionally pre-raise the other VM's verdict.
   task automatic serve_one(int nw);
      pkt_t e = pend[0];
      if (!raised[e.b]) raise(e.b, e.acc);
      if ($urandom_range(0, 1) == 1) begin
         for (int j = 1; j < pend.size(); j++) begin
            if (pend[j].b != e.b) begin
               if (!raised[pend[j].b]) raise(pend[j].b, pend[j].acc);
               break;
            end
         end
      end
      wait_ack(e.b, "serve");
      void'(pend.pop_front());
      if (e.acc) fwd_packet(e.b, (nw > 0) ? nw : int'($urandom_range(1, 6)));
   endtask

   initial begin
      bit nb;
      pkt_t e;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 1024; a++) mem[b][a] = {$urandom(), $urandom()};
      rst = 1'b1;
      bus.sel_in = 0; bus.sel_wr = 0;
      bus.vld_left = 0; bus.acc_left = 0; bus.vld_right = 0; bus.acc_right = 0;
      bus.fwd_rd_en = 0; bus.fwd_done = 0; bus.fwd_rd_addr = 10'h155;
      #2;
      chk("rst_sel_full", bus.sel_full, 1'b0);
      chk("rst_overflow", bus.overflow, 1'b0);
      chk("rst_ack_l", bus.ack_left, 1'b0);
      chk("rst_ack_r", bus.ack_right, 1'b0);
      chk("rst_rden_l", bus.rd_en_left, 1'b0);
      chk("rst_rden_r", bus.rd_en_right, 1'b0);
      chk("rst_addr_l", bus.rd_addr_left, 0);
      chk("rst_addr_r", bus.rd_addr_right, 0);
      chk("rst_done_l", bus.done_left, 1'b0);
      chk("rst_done_r", bus.done_right, 1'b0);
      chk("rst_ready", bus.fwd_pkt_ready, 1'b0);
      chk("rst_src", bus.fwd_src, 1'b0);
      chk("rst_rdata", bus.fwd_rd_data, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      bus.fwd_rd_addr = '0;
      @(negedge clk);

      // 1: L,R,L all accepted, four words each
      push(0, 1, 1); push(1, 1, 1); push(0, 1, 1);
      while (pend.size() > 0) serve_one(4);

      // 2: right verdict early must wait behind left
      push(0, 1, 1); push(1, 1, 1);
      raise(1, 1);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("early_ack_r", bus.ack_right, 1'b0);
         @(negedge clk);
      end
      while (pend.size() > 0) serve_one(4);

      // 3: lone right reject
      push(1, 0, 1);
      serve_one(0);
      for (int i = 0; i < 3; i++) begin
         bus.fwd_rd_en = 1'b1;
         #1;
         chk("rej_ack_r", bus.ack_right, 1'b0);
         chk("rej_rden_r", bus.rd_en_right, 1'b0);
         chk("rej_done_r", bus.done_right, 1'b0);
         chk("rej_ready", bus.fwd_pkt_ready, 1'b0);
         @(negedge clk);
      end
      bus.fwd_rd_en = 1'b0;

      // 4: fill, overflow, push+pop while full, drain
      for (int i = 0; i < DEPTH; i++) push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      #1;
      chk("full16", bus.sel_full, 1'b1);
      chk("no_ovf16", bus.overflow, 1'b0);
      @(negedge clk);
      push(1'($urandom_range(0, 1)), 0, 0);
      #1;
      chk("ovf17", bus.overflow, 1'b1);
      chk("full17", bus.sel_full, 1'b1);
      @(negedge clk);
      e  = pend[0];
      nb = 1'($urandom_range(0, 1));
      raise(e.b, 0);
      bus.sel_wr = 1'b1;
      bus.sel_in = nb;
      #1;
      chk("pp_ack", ack_o(e.b), 1'b1);
      @(negedge clk);
      bus.sel_wr = 1'b0;
      drop(e.b);
      void'(pend.pop_front());
      pend.push_back(pkt_t'{b: nb, acc: 1'($urandom_range(0, 1))});
      #1;
      chk("pp_full", bus.sel_full, 1'b1);
      @(negedge clk);
      while (pend.size() > 0) serve_one(0);
      #1;
      chk("drained_full", bus.sel_full, 1'b0);
      chk("ovf_sticky", bus.overflow, 1'b1);
      @(negedge clk);

      // 5: reset after 2 of 4 reads
      push(0, 1, 0);
      raise(0, 1);
      wait_ack(0, "t5");
      bus.fwd_rd_en = 1'b1; bus.fwd_rd_addr = 10'd20;
      @(negedge clk);
      bus.fwd_rd_addr = 10'd21;
      @(negedge clk);
      bus.fwd_rd_addr = 10'd22;
      rst = 1'b1;
      #1;
      chk("mid_rden_l", bus.rd_en_left, 1'b0);
      chk("mid_rden_r", bus.rd_en_right, 1'b0);
      chk("mid_addr_l", bus.rd_addr_left, 0);
      chk("mid_done_l", bus.done_left, 1'b0);
      chk("mid_ready", bus.fwd_pkt_ready, 1'b0);
      chk("mid_rdata", bus.fwd_rd_data, 0);
      chk("mid_src", bus.fwd_src, 1'b0);
      chk("mid_ovf", bus.overflow, 1'b0);
      chk("mid_full", bus.sel_full, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      bus.fwd_rd_en = 1'b0;
      bus.fwd_rd_addr = '0;
      raise(0, 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("post_rst_ack", bus.ack_left, 1'b0);
         chk("post_rst_ready", bus.fwd_pkt_ready, 1'b0);
         @(negedge clk);
      end
      drop(0);
      push(1, 1, 1);
      serve_one(4);

      // 6: fwd_done / fwd_rd_en outside FWD
      bus.fwd_done = 1'b1;
      #1;
      chk("idle_done_l", bus.done_left, 1'b0);
      chk("idle_done_r", bus.done_right, 1'b0);
      @(negedge clk);
      bus.fwd_done = 1'b0;
      push(0, 1, 1);
      @(negedge clk); @(negedge clk);
      bus.fwd_done = 1'b1;
      bus.fwd_rd_en = 1'b1;
      #1;
      chk("wait_done_l", bus.done_left, 1'b0);
      chk("wait_rden_l", bus.rd_en_left, 1'b0);
      chk("wait_rden_r", bus.rd_en_right, 1'b0);
      chk("wait_ready", bus.fwd_pkt_ready, 1'b0);
      chk("wait_rdata", bus.fwd_rd_data, 0);
      @(negedge clk);
      bus.fwd_done = 1'b0;
      bus.fwd_rd_en = 1'b0;
      serve_one(3);

      // Randomized bursts against the arrival-order model
      for (int r = 0; r < 6; r++) begin
         int k = $urandom_range(1, 8);
         for (int i = 0; i < k; i++) push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
         while (pend.size() > 0) serve_one(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
